// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared definitions for the SD command-line scheduler.
//   state_t    : scheduler FSM state encoding
//   FRAME_LEN  : length of a command / response frame on the CMD line
//   CMD*       : command index constants
//   CRC7_POLY  : x^7 + x^3 + 1 (the x^7 term is implicit)
//   crc7_next  : one bit-serial CRC7 step
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_RESP,
        ST_RECV,
        ST_GAP
    } state_t;

    localparam int FRAME_LEN = 48;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD24  = 6'd24;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: bit-serial CRC7 accumulator, MSB-first data.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force the register to zero (wins over en)
//   en         : absorb din this cycle
//   din        : data bit
//   crc        : current remainder
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7_next(crc, din);
        end
    end

endmodule

// File: rtl/sd_cmd_sched.sv
// sd_cmd_sched: arbitrates two requesters onto one SD CMD line, serialises the
// 48-bit command frame, optionally collects a 48-bit response, then enforces
// an idle gap.
//   clk, rst_n           : the SD clock, synchronous active-low reset
//   init_* / rw_*        : requester 0 / 1: req, cmd index, arg, resp_en
//   gnt                  : one-hot grant, held for the whole transaction
//   busy                 : grant through end of gap
//   sd_cmd_o / sd_cmd_i  : CMD line to / from the card (both idle high)
//   done, done_id        : completion pulse and owning requester
//   resp, timeout, crc_err : result, valid with done, held until next grant
//
// state        | meaning
// ST_IDLE      | waiting for a request, round-robin arbitration
// ST_LOAD      | latch granted command, drive start bit next
// ST_SEND      | shifting frame bits out on sd_cmd_o
// ST_WAIT_RESP | watching sd_cmd_i for the response start bit
// ST_RECV      | shifting in the remaining 47 response bits
// ST_GAP       | enforced idle cycles before releasing the grant
module sd_cmd_sched
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int GAP     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic [5:0]  init_cmd,
    input  logic [31:0] init_arg,
    input  logic        init_resp_en,
    input  logic        rw_req,
    input  logic [5:0]  rw_cmd,
    input  logic [31:0] rw_arg,
    input  logic        rw_resp_en,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        sd_cmd_o,
    input  logic        sd_cmd_i,
    output logic        done,
    output logic        done_id,
    output logic [47:0] resp,
    output logic        timeout,
    output logic        crc_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t        state;
    logic [5:0]    tx_idx;     // frame bit currently on sd_cmd_o
    logic [5:0]    rx_idx;     // response bit sampled at the next edge
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gap_cnt;
    logic [39:0]   tx_data;    // frame bits 47..8
    logic          resp_en_q;
    logic          last_rw;    // 1 when rw owned the previous grant
    logic [46:0]   rx_sh;

    logic          pick_rw;
    logic [5:0]    tx_nxt;
    logic [2:0]    crc_idx;
    logic          tx_bit;
    logic          crc_clr;
    logic          crc_en;
    logic          crc_din;
    logic [6:0]    crc;

    assign pick_rw = rw_req && (!init_req || !last_rw);
    assign tx_nxt  = tx_idx - 6'd1;
    assign crc_idx = tx_nxt[2:0] - 3'd1;

    // Bits 7..1 come straight from the CRC register, which has absorbed
    // bits 47..8 by the edge that loads bit 7.
    always_comb begin
        tx_bit = 1'b1;
        if (tx_nxt >= 6'd8) begin
            tx_bit = tx_data[tx_nxt - 6'd8];
        end else if (tx_nxt != 6'd0) begin
            tx_bit = crc[crc_idx];
        end
    end

    // The CRC absorbs each bit at the same edge it is loaded onto or sampled
    // from the line; the start bit is always 0.
    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_din = 1'b0;
        unique case (state)
            ST_IDLE, ST_GAP: crc_clr = 1'b1;
            ST_LOAD:         crc_en  = 1'b1;
            ST_SEND: begin
                if (tx_idx == 6'd0) begin
                    crc_clr = 1'b1;
                end else if (tx_nxt >= 6'd8) begin
                    crc_en  = 1'b1;
                    crc_din = tx_bit;
                end
            end
            ST_WAIT_RESP:    crc_en  = !sd_cmd_i;
            ST_RECV: begin
                if (rx_idx >= 6'd8) begin
                    crc_en  = 1'b1;
                    crc_din = sd_cmd_i;
                end
            end
            default: ;
        endcase
    end

    sd_crc7 u_crc7 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            sd_cmd_o  <= 1'b1;
            done      <= 1'b0;
            done_id   <= 1'b0;
            resp      <= '0;
            timeout   <= 1'b0;
            crc_err   <= 1'b0;
            last_rw   <= 1'b1;
            tx_idx    <= '0;
            rx_idx    <= '0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
            tx_data   <= '0;
            resp_en_q <= 1'b0;
            rx_sh     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (init_req || rw_req) begin
                        state   <= ST_LOAD;
                        busy    <= 1'b1;
                        gnt     <= pick_rw ? 2'b10 : 2'b01;
                        last_rw <= pick_rw;
                        resp    <= '0;
                        timeout <= 1'b0;
                        crc_err <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    tx_data   <= gnt[1] ? {2'b01, rw_cmd, rw_arg} : {2'b01, init_cmd, init_arg};
                    resp_en_q <= gnt[1] ? rw_resp_en : init_resp_en;
                    sd_cmd_o  <= 1'b0;
                    tx_idx    <= 6'(FRAME_LEN - 1);
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_idx == 6'd0) begin
                        sd_cmd_o <= 1'b1;
                        if (resp_en_q) begin
                            to_cnt <= TO_LOAD;
                            state  <= ST_WAIT_RESP;
                        end else begin
                            done    <= 1'b1;
                            done_id <= last_rw;
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end
                    end else begin
                        sd_cmd_o <= tx_bit;
                        tx_idx   <= tx_nxt;
                    end
                end
                ST_WAIT_RESP: begin
                    if (!sd_cmd_i) begin
                        rx_sh  <= '0;
                        rx_idx <= 6'(FRAME_LEN - 2);
                        state  <= ST_RECV;
                    end else if (to_cnt <= TW'(1)) begin
                        timeout <= 1'b1;
                        resp    <= '0;
                        done    <= 1'b1;
                        done_id <= last_rw;
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                    end else begin
                        to_cnt <= to_cnt - TW'(1);
                    end
                end
                ST_RECV: begin
                    rx_sh <= {rx_sh[45:0], sd_cmd_i};
                    if (rx_idx == 6'd0) begin
                        // rx_sh holds bits 47..1; the end bit is on the line now.
                        resp    <= {rx_sh, sd_cmd_i};
                        crc_err <= (rx_sh[6:0] != crc) || !sd_cmd_i;
                        done    <= 1'b1;
                        done_id <= last_rw;
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                    end else begin
                        rx_idx <= rx_idx - 6'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        gnt   <= 2'b00;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
